// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - bit-serial add/subtract unit driving one full adder LSB-first
// Accepts an op over a start handshake, runs WIDTH single-bit steps, returns result and flags.

module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cIn,
  output logic sum,
  output logic cOut
);
  assign sum  = a ^ b ^ cIn;
  assign cOut = (a & b) | (cIn & (a ^ b));
endmodule

module serial_add_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             flush,
  input  logic             startValid,
  output logic             startReady,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             sub,
  output logic             resValid,
  input  logic             resReady,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_msb_cin;
  logic             r_zero;
  logic             r_start_ready;

  logic w_sum;
  logic w_cout;

  fullAdder u_full_adder (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cIn  (r_carry),
    .sum  (w_sum),
    .cOut (w_cout)
  );

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_result      <= '0;
      r_carry       <= 1'b0;
      r_msb_cin     <= 1'b0;
      r_zero        <= 1'b0;
      r_start_ready <= 1'b0;
    end else if (flush) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_result      <= '0;
      r_carry       <= 1'b0;
      r_msb_cin     <= 1'b0;
      r_zero        <= 1'b0;
      r_start_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (startValid && r_start_ready) begin
            // Subtraction is A + ~B + 1: invert B here, seed the carry with sub.
            r_a           <= opA;
            r_b           <= opB ^ {WIDTH{sub}};
            r_carry       <= sub;
            r_cnt         <= '0;
            r_zero        <= 1'b1;
            r_state       <= S_RUN;
            r_start_ready <= 1'b0;
          end else begin
            r_start_ready <= 1'b1;
          end
        end
        S_RUN: begin
          r_a      <= {1'b0, r_a[WIDTH-1:1]};
          r_b      <= {1'b0, r_b[WIDTH-1:1]};
          r_result <= {w_sum, r_result[WIDTH-1:1]};
          r_carry  <= w_cout;
          r_zero   <= r_zero & ~w_sum;
          if (r_cnt == LAST_BIT) begin
            r_msb_cin <= r_carry;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (resReady) begin
            r_state       <= S_IDLE;
            r_start_ready <= 1'b1;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_start_ready <= 1'b0;
        end
      endcase
    end
  end

  assign startReady = r_start_ready;
  assign resValid   = (r_state == S_DONE);
  assign result     = r_result;
  assign carryOut   = r_carry;
  assign overflow   = r_carry ^ r_msb_cin;
  assign zero       = r_zero;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - directed bench for serial_add_sequencer
// Hand-computed vectors for add/sub flags, backpressure, flush and reset.

module tb_serial_add_sequencer;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rstN;
  logic             flush;
  logic             startValid;
  logic             startReady;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             sub;
  logic             resValid;
  logic             resReady;
  logic [WIDTH-1:0] result;
  logic             carryOut;
  logic             overflow;
  logic             zero;

  int n_cmp = 0;
  int n_bad = 0;

  serial_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .flush      (flush),
    .startValid (startValid),
    .startReady (startReady),
    .opA        (opA),
    .opB        (opB),
    .sub        (sub),
    .resValid   (resValid),
    .resReady   (resReady),
    .result     (result),
    .carryOut   (carryOut),
    .overflow   (overflow),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic s);
    chk({tag, "_ready"}, 64'(startReady), 64'd1);
    opA = a; opB = b; sub = s; startValid = 1'b1;
    tick();
    startValid = 1'b0;
    opA = $urandom; opB = $urandom; sub = ~s;
  endtask

  task automatic run_to_done(input string tag);
    logic early;
    early = 1'b0;
    for (int i = 1; i < WIDTH; i++) begin
      tick();
      if (resValid !== 1'b0) early = 1'b1;
    end
    chk({tag, "_early_valid"}, 64'(early), 64'd0);
    tick();
    chk({tag, "_valid"}, 64'(resValid), 64'd1);
  endtask

  task automatic chk_res(input string tag, input logic [WIDTH-1:0] r,
                         input logic c, input logic v, input logic z);
    chk({tag, "_result"}, 64'(result), 64'(r));
    chk({tag, "_flags"}, 64'({carryOut, overflow, zero}), 64'({c, v, z}));
  endtask

  task automatic release_res(input string tag);
    resReady = 1'b1;
    tick();
    resReady = 1'b0;
    chk({tag, "_drop_valid"}, 64'(resValid), 64'd0);
    chk({tag, "_idle_ready"}, 64'(startReady), 64'd1);
  endtask

  task automatic full_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s, input logic [WIDTH-1:0] r,
                         input logic c, input logic v, input logic z);
    start_op(tag, a, b, s);
    run_to_done(tag);
    chk_res(tag, r, c, v, z);
    release_res(tag);
  endtask

  initial begin
    logic bad;
    logic [WIDTH-1:0] held;

    rstN = 1'b0; flush = 1'b0; startValid = 1'b0; resReady = 1'b0;
    opA = '0; opB = '0; sub = 1'b0;
    tick();
    chk("rst_ready", 64'(startReady), 64'd0);
    chk("rst_valid", 64'(resValid), 64'd0);
    chk_res("rst", 32'h0, 1'b0, 1'b0, 1'b0);
    rstN = 1'b1;
    tick();
    chk("post_rst_ready", 64'(startReady), 64'd1);

    full_op("add5_3", 32'd5, 32'd3, 1'b0, 32'h00000008, 1'b0, 1'b0, 1'b0);
    full_op("add_ovf", 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    full_op("add_wrap", 32'hFFFFFFFF, 32'h1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    full_op("sub5_5", 32'd5, 32'd5, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    full_op("sub0_1", 32'd0, 32'd1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    full_op("sub_ovf", 32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);

    // Backpressure: held DONE with a competing start request.
    start_op("bp", 32'h12345678, 32'h11111111, 1'b0);
    run_to_done("bp");
    chk_res("bp", 32'h23456789, 1'b0, 1'b0, 1'b0);
    held = result;
    bad = 1'b0;
    startValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      opA = $urandom; opB = $urandom; sub = i[0];
      tick();
      if (resValid !== 1'b1 || startReady !== 1'b0 || result !== held ||
          {carryOut, overflow, zero} !== 3'b000) bad = 1'b1;
    end
    chk("bp_hold", 64'(bad), 64'd0);
    startValid = 1'b0;
    release_res("bp");
    chk("bp_keep_result", 64'(result), 64'h23456789);

    // Flush on the 10th RUN cycle.
    start_op("fl", 32'd7, 32'd7, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", 64'(resValid), 64'd0);
    chk("fl_result", 64'(result), 64'd0);
    chk("fl_ready", 64'(startReady), 64'd1);
    bad = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      tick();
      if (resValid !== 1'b0) bad = 1'b1;
    end
    chk("fl_no_valid", 64'(bad), 64'd0);
    full_op("add2_2", 32'd2, 32'd2, 1'b0, 32'd4, 1'b0, 1'b0, 1'b0);

    // flush together with startValid in IDLE must not accept.
    flush = 1'b1; startValid = 1'b1; opA = 32'd1; opB = 32'd1; sub = 1'b0;
    tick();
    flush = 1'b0; startValid = 1'b0;
    chk("flidle_ready", 64'(startReady), 64'd1);
    bad = 1'b0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      tick();
      if (resValid !== 1'b0) bad = 1'b1;
    end
    chk("flidle_no_valid", 64'(bad), 64'd0);

    // Reset mid-RUN.
    start_op("rrun", 32'hFFFF0000, 32'h0000FFFF, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    chk("rrun_ready0", 64'(startReady), 64'd0);
    chk("rrun_valid", 64'(resValid), 64'd0);
    chk_res("rrun", 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rrun_ready1", 64'(startReady), 64'd1);

    // Reset during DONE.
    start_op("rdone", 32'hFFFFFFFF, 32'h1, 1'b0);
    run_to_done("rdone");
    chk_res("rdone_pre", 32'h0, 1'b1, 1'b0, 1'b1);
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    chk("rdone_valid", 64'(resValid), 64'd0);
    chk_res("rdone", 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rdone_ready1", 64'(startReady), 64'd1);

    full_op("after_rst", 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 32'h4B4B4B4B, 1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
- Multi-cycle, bit-serial add/subtract unit for area-reduced RV32I builds.
- Owns exactly one fullAdder instance and sequences it LSB-first across WIDTH cycles, holding the carry between bits in a flop.
- Accepts an operation over a valid/ready start handshake and returns the result and flags over a valid/ready result handshake.
- Sits beside the ALU and is used for ADD/SUB/ADDI and the compare paths when the parallel adder is omitted.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 2).

Ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- rstN  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- flush  input  1  synchronous abort; drops any in-flight or completed operation.
- startValid  input  1  operation request.
- startReady  output  1  unit can accept an operation.
- opA  input  WIDTH  first operand.
- opB  input  WIDTH  second operand.
- sub  input  1  0: opA+opB; 1: opA-opB (two's complement).
- resValid  output  1  result and flags valid.
- resReady  input  1  consumer accepts the result.
- result  output  WIDTH  sum/difference modulo 2^WIDTH.
- carryOut  output  1  carry out of MSB; for sub, 1 = no borrow (opA >= opB unsigned).
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.

Behaviour:
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset (rstN=0 at an edge):
  - State goes to IDLE, bit counter to 0, carry flop to 0.
  - All operand/result registers go to 0.
  - Outputs: startReady=0 during the reset cycle and 1 from the first non-reset edge; resValid=0, result=0, carryOut=0, overflow=0, zero=0.
  - Reset applies from any state, including mid-RUN.
- Priority at each edge: rstN, then flush, then handshakes.
- flush=1:
  - From RUN or DONE, go to IDLE next cycle and discard the result.
  - resValid never asserts for the aborted operation.
  - Output registers return to 0.
  - In IDLE, flush blocks acceptance even if startValid=1.
- IDLE:
  - startReady=1, resValid=0.
  - Accept when startValid & startReady & !flush.
  - On accept, load the A shift register with opA, the B shift register with opB XOR {WIDTH{sub}}, set the carry flop to sub, clear the counter, set the zero-tracker to 1, then go to RUN.
- RUN:
  - startReady=0, resValid=0.
  - Each cycle, the fullAdder takes a=A[0], b=B[0], cIn=carry flop.
  - Its sum shifts into the result register MSB (result shifts right).
  - A and B shift right; the carry flop takes cOut; the zero-tracker ANDs with ~sum; the counter increments.
  - On the cycle with counter == WIDTH-1, also capture msbCarryIn = carry flop value (carry into the MSB).
  - After that cycle, go to DONE.
- Latency: accept at edge T; resValid=1 after edge T+WIDTH (WIDTH RUN cycles). Minimum back-to-back cadence is WIDTH+2 cycles (accept, WIDTH RUN cycles, one DONE handoff).
- DONE:
  - resValid=1.
  - result, carryOut = carry flop, overflow = carry flop XOR msbCarryIn, and zero are held stable while resReady=0.
  - startReady=0, so startValid is ignored and no operation is accepted in the handoff cycle.
  - On resValid & resReady, go to IDLE; resValid drops the next cycle and outputs keep their last values until the next accept.
- Arithmetic: everything is modulo 2^WIDTH; operands are not sign-extended; sub uses the inverted B plus carry-in 1.
- opA, opB and sub are sampled only at the accept edge; later changes have no effect.
- The counter is $clog2(WIDTH) bits wide and never wraps past WIDTH-1 inside RUN.

Test Plan:
- WIDTH=32, add 5+3 -> result=0x00000008, carryOut=0, overflow=0, zero=0; resValid rises exactly 32 cycles after the accept edge.
- Add 0x7FFFFFFF+0x00000001 -> result 0x80000000, overflow=1, carryOut=0. Add 0xFFFFFFFF+0x00000001 -> result 0, carryOut=1, zero=1, overflow=0.
- Sub 5-5 -> result 0, zero=1, carryOut=1, overflow=0. Sub 0-1 -> 0xFFFFFFFF, carryOut=0, overflow=0. Sub 0x80000000-1 -> 0x7FFFFFFF, overflow=1, carryOut=1.
- Backpressure: hold resReady=0 for 10 cycles in DONE with startValid=1 and opA/opB toggling -> outputs constant, startReady=0, no new accept; raise resReady -> one handoff, then startReady=1 on the following cycle.
- flush asserted on the 10th RUN cycle -> IDLE next cycle, resValid stays 0, and a new add 2+2 then completes with 4 after 32 cycles. flush and startValid together in IDLE -> no accept.
- rstN=0 for one cycle mid-RUN and again during DONE -> next cycle state is IDLE, resValid=0, result/flags=0, startReady=1 after the reset cycle.
